program_launcher: RTL and testbench

- Upstream sequencer for the 9-bit-instruction processor core.
- Holds a small table of program start addresses and launches each program in turn through the core's `start`/`start_address` inputs.
- Waits for the core's `done` (halt) and records the cycle count of each run.
- Reports per-program results and a final completion pulse to the test or host side.

---
 rtl/program_launcher_pkg.sv | 17 +
 rtl/launch_table.sv | 49 ++++
 rtl/program_launcher.sv | 187 ++++++++++++++++++
 tb/tb_program_launcher.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_launcher_pkg.sv
// Shared types and constants for the program launcher and its start-address table.
package program_launcher_pkg;

    // Width of a table index; also the width of cfg_idx and res_idx.
    localparam int IDX_W          = 3;
    localparam int DEFAULT_ADDR_W = 7;
    localparam int DEFAULT_CYC_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        RECORD,
        FINISH
    } launcher_state_t;

endpackage

// File: rtl/launch_table.sv
// Start-address table: one register per program, synchronous write and reset,
// combinational read so a launch can present the entry in the same cycle.
module launch_table
    import program_launcher_pkg::*;
#(
    parameter int NUM_PROGS = 3,
    parameter int ADDR_W    = DEFAULT_ADDR_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [ADDR_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [ADDR_W-1:0] rdata_o
);

    logic [ADDR_W-1:0] mem_q [NUM_PROGS];

    // Entry storage: cleared by reset, written one entry at a time.
    // NOTE: this array is reset on purpose -- a launch after reset must read 0,
    // so it is built from flops rather than left to a RAM macro with no reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                if (widx_i == IDX_W'(i)) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    // Read mux; indices past the table return 0.
    // NOTE: rdata_o is assigned before the loop so no path leaves it unset (no latch).
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (ridx_i == IDX_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/program_launcher.sv
// Sequencer that launches each table entry on the core, waits for its halt,
// and reports the per-program cycle count. All outputs come straight from flops.
module program_launcher
    import program_launcher_pkg::*;
#(
    parameter int               NUM_PROGS    = 3,
    parameter int               ADDR_W       = DEFAULT_ADDR_W,
    parameter int               CYC_W        = DEFAULT_CYC_W,
    parameter int               START_CYCLES = 2,
    parameter logic [CYC_W-1:0] TIMEOUT      = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              go,
    input  logic              done,
    output logic              start,
    output logic [ADDR_W-1:0] start_address,
    output logic              busy,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_idx,
    output logic [CYC_W-1:0]  res_cycles,
    output logic              timeout_err,
    output logic              all_done
);

    localparam int               LCNT_W    = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] LAST_LCNT = LCNT_W'(START_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PROGS - 1);

    launcher_state_t   state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              start_q, start_d;
    logic [ADDR_W-1:0] start_address_q, start_address_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;
    logic [IDX_W-1:0]  res_idx_q, res_idx_d;
    logic [CYC_W-1:0]  res_cycles_q, res_cycles_d;
    logic              timeout_err_q, timeout_err_d;
    logic              all_done_q, all_done_d;

    logic              wr_en;
    logic [ADDR_W-1:0] table_rdata;
    logic [ADDR_W-1:0] launch_addr;

    // Table writes only land while idle and for an index inside the table.
    assign wr_en = cfg_we && !busy_q && (int'(cfg_idx) < NUM_PROGS);

    launch_table #(
        .NUM_PROGS (NUM_PROGS),
        .ADDR_W    (ADDR_W)
    ) u_table (
        .clk_i   (CLK),
        .reset_i (reset),
        .we_i    (wr_en),
        .widx_i  (cfg_idx),
        .wdata_i (cfg_addr),
        .ridx_i  (idx_d),
        .rdata_o (table_rdata)
    );

    // A write on the go edge must reach the first launch, so forward it past the table.
    assign launch_addr = (wr_en && (cfg_idx == idx_d)) ? cfg_addr : table_rdata;

    // Next-state logic: sequencing, run counting, timeout and result capture.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lcnt_d        = lcnt_q;
        cyc_d         = cyc_q;
        res_valid_d   = 1'b0;
        res_idx_d     = res_idx_q;
        res_cycles_d  = res_cycles_q;
        timeout_err_d = timeout_err_q;
        all_done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d       = LAUNCH;
                    idx_d         = '0;
                    lcnt_d        = '0;
                    timeout_err_d = 1'b0;
                end
            end
            LAUNCH: begin
                // done is ignored here: the core may still show the previous halt.
                if (lcnt_q == LAST_LCNT) begin
                    state_d = RUN;
                    cyc_d   = '0;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            RUN: begin
                // Counter is 0 only on the first RUN cycle, when the core is settling.
                if (cyc_q == '0) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end else if (done) begin
                    state_d      = RECORD;
                    res_valid_d  = 1'b1;
                    res_idx_d    = idx_q;
                    res_cycles_d = cyc_q;
                end else if (cyc_q == TIMEOUT) begin
                    state_d       = RECORD;
                    res_valid_d   = 1'b1;
                    res_idx_d     = idx_q;
                    res_cycles_d  = TIMEOUT;
                    timeout_err_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            RECORD: begin
                if (idx_q == LAST_IDX) begin
                    state_d    = FINISH;
                    all_done_d = 1'b1;
                end else begin
                    state_d = LAUNCH;
                    idx_d   = idx_q + IDX_W'(1);
                    lcnt_d  = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core-facing outputs follow the state being entered, so start rises on the go edge.
    always_comb begin
        start_d         = (state_d == LAUNCH);
        busy_d          = (state_d != IDLE);
        start_address_d = start_address_q;
        if (state_d == LAUNCH) begin
            start_address_d = launch_addr;
        end
    end

    // State and registered outputs; reset returns everything to IDLE/zero in one edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            lcnt_q          <= '0;
            cyc_q           <= '0;
            start_q         <= 1'b0;
            start_address_q <= '0;
            busy_q          <= 1'b0;
            res_valid_q     <= 1'b0;
            res_idx_q       <= '0;
            res_cycles_q    <= '0;
            timeout_err_q   <= 1'b0;
            all_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            lcnt_q          <= lcnt_d;
            cyc_q           <= cyc_d;
            start_q         <= start_d;
            start_address_q <= start_address_d;
            busy_q          <= busy_d;
            res_valid_q     <= res_valid_d;
            res_idx_q       <= res_idx_d;
            res_cycles_q    <= res_cycles_d;
            timeout_err_q   <= timeout_err_d;
            all_done_q      <= all_done_d;
        end
    end

    assign start         = start_q;
    assign start_address = start_address_q;
    assign busy          = busy_q;
    assign res_valid     = res_valid_q;
    assign res_idx       = res_idx_q;
    assign res_cycles    = res_cycles_q;
    assign timeout_err   = timeout_err_q;
    assign all_done      = all_done_q;

endmodule

// File: tb/tb_program_launcher.sv
// Bench for program_launcher: a core stub drives done a chosen number of cycles
// into each run; expected timing and results are worked out from the launch rules.
module tb_program_launcher;

    localparam int NUM_PROGS    = 3;
    localparam int ADDR_W       = 7;
    localparam int CYC_W        = 16;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 10;

    logic              CLK = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [2:0]        cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic              go;
    logic              done;
    logic              start;
    logic [ADDR_W-1:0] start_address;
    logic              busy;
    logic              res_valid;
    logic [2:0]        res_idx;
    logic [CYC_W-1:0]  res_cycles;
    logic              timeout_err;
    logic              all_done;

    program_launcher #(
        .NUM_PROGS    (NUM_PROGS),
        .ADDR_W       (ADDR_W),
        .CYC_W        (CYC_W),
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (16'(TIMEOUT))
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_addr      (cfg_addr),
        .go            (go),
        .done          (done),
        .start         (start),
        .start_address (start_address),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_idx       (res_idx),
        .res_cycles    (res_cycles),
        .timeout_err   (timeout_err),
        .all_done      (all_done)
    );

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference table and per-program halt delay (RUN cycle on which done rises; 0 = always high).
    int tbl  [NUM_PROGS];
    int rise [NUM_PROGS];
    int run_k;
    int cur_prog;
    bit prev_start;
    bit exp_te;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Advance to the next sampling point and update the core stub's done level.
    task automatic tick();
        @(negedge CLK);
        if (start === 1'b1) begin
            if (!prev_start) cur_prog++;
            run_k = 0;
        end else if (run_k < 100000) begin
            run_k++;
        end
        prev_start = (start === 1'b1);
        if (cur_prog >= 0 && cur_prog < NUM_PROGS) done = (run_k >= rise[cur_prog]);
        else done = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start"}, start, 0);
        check({tag, "_addr"}, start_address, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_idx"}, res_idx, 0);
        check({tag, "_res_cycles"}, res_cycles, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_all_done"}, all_done, 0);
    endtask

    task automatic cfg_write(input logic [2:0] i, input logic [ADDR_W-1:0] a);
        cfg_we = 1'b1; cfg_idx = i; cfg_addr = a;
        tick();
        cfg_we = 1'b0;
        if (int'(i) < NUM_PROGS) tbl[i] = int'(a);
    endtask

    // Inputs that must have no effect while busy: 0 quiet, 1 random, 2 fixed write idx2=99 plus go.
    task automatic busy_noise(input int mode);
        if (mode == 1) begin
            go       = 1'($urandom_range(0, 1));
            cfg_we   = 1'($urandom_range(0, 1));
            cfg_idx  = 3'($urandom_range(0, 7));
            cfg_addr = 7'($urandom_range(0, 127));
        end else if (mode == 2) begin
            go = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd2; cfg_addr = 7'd99;
        end
    endtask

    // One full sequence from the go edge to IDLE, checked cycle by cycle.
    task automatic run_seq(input int mode, input bit go_wr, input logic [2:0] wr_idx,
                           input logic [ADDR_W-1:0] wr_addr, input int abort_p);
        int r;
        int res;
        bit to;
        cur_prog = -1; prev_start = 1'b0; run_k = 0;
        go = 1'b1;
        if (go_wr) begin
            cfg_we = 1'b1; cfg_idx = wr_idx; cfg_addr = wr_addr;
            if (int'(wr_idx) < NUM_PROGS) tbl[wr_idx] = int'(wr_addr);
        end
        exp_te = 1'b0;
        tick();
        go = 1'b0; cfg_we = 1'b0;
        for (int p = 0; p < NUM_PROGS; p++) begin
            r  = (rise[p] < 2) ? 2 : rise[p];
            to = (r - 1 > TIMEOUT);
            if (to) r = TIMEOUT + 1;
            res = r - 1;
            for (int c = 0; c < START_CYCLES; c++) begin
                check("launch_start", start, 1);
                check("launch_addr", start_address, tbl[p]);
                check("launch_busy", busy, 1);
                check("launch_te", timeout_err, exp_te);
                busy_noise(mode);
                tick();
            end
            for (int c = 1; c <= r; c++) begin
                check("run_start", start, 0);
                check("run_addr", start_address, tbl[p]);
                check("run_res_valid", res_valid, 0);
                check("run_te", timeout_err, exp_te);
                if (p == abort_p && c == 2) begin
                    go = 1'b0; cfg_we = 1'b0; reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    check_reset_state("abort");
                    for (int i = 0; i < NUM_PROGS; i++) tbl[i] = 0;
                    return;
                end
                busy_noise(mode);
                tick();
            end
            if (to) exp_te = 1'b1;
            check("rec_valid", res_valid, 1);
            check("rec_idx", res_idx, p);
            check("rec_cycles", res_cycles, res);
            check("rec_te", timeout_err, exp_te);
            check("rec_start", start, 0);
            busy_noise(mode);
            tick();
        end
        check("fin_all_done", all_done, 1);
        check("fin_busy", busy, 1);
        check("fin_res_valid", res_valid, 0);
        go = 1'b0; cfg_we = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_all_done", all_done, 0);
        check("idle_start", start, 0);
        check("idle_te", timeout_err, exp_te);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; go = 1'b0; done = 1'b0;
        cur_prog = -1; prev_start = 1'b0; run_k = 0; exp_te = 1'b0;
        for (int i = 0; i < NUM_PROGS; i++) begin tbl[i] = 0; rise[i] = 2; end
        tick(); tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        // Basic sequence with distinct halt delays.
        cfg_write(3'd0, 7'd0); cfg_write(3'd1, 7'd20); cfg_write(3'd2, 7'd45);
        rise[0] = 5; rise[1] = 9; rise[2] = 3;
        run_seq(0, 1'b0, 3'd0, 7'd0, -1);

        // done high throughout: ignored until the second RUN cycle.
        rise[0] = 0; rise[1] = 0; rise[2] = 0;
        run_seq(0, 1'b0, 3'd0, 7'd0, -1);

        // Entry 1 never halts; entry 2 still runs; the next go clears the flag.
        rise[0] = 4; rise[1] = 1000; rise[2] = 6;
        run_seq(0, 1'b0, 3'd0, 7'd0, -1);
        rise[0] = 11; rise[1] = 12; rise[2] = 3;
        run_seq(0, 1'b0, 3'd0, 7'd0, -1);

        // Out-of-range write in IDLE, then writes and go held high while busy.
        cfg_write(3'd5, 7'd99);
        rise[0] = 3; rise[1] = 2; rise[2] = 4;
        run_seq(2, 1'b0, 3'd0, 7'd0, -1);

        // Write on the go edge feeds the first launch.
        run_seq(2, 1'b1, 3'd0, 7'd33, -1);

        // Reset during RUN of entry 1, then a launch from the cleared table.
        rise[0] = 3; rise[1] = 6; rise[2] = 4;
        run_seq(0, 1'b0, 3'd0, 7'd0, 1);
        tick();
        run_seq(0, 1'b0, 3'd0, 7'd0, -1);

        // Randomized sequences.
        for (int n = 0; n < 25; n++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) cfg_write(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)));
            for (int i = 0; i < NUM_PROGS; i++) rise[i] = $urandom_range(0, 14);
            run_seq(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NUM_PROGS - 1)) : -1);
            go = 1'b0; cfg_we = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
